// File: rtl/tick_timer.sv
// tick_timer: prescaled countdown timer with one-shot/periodic modes, pause and stop.
// Define TIMER_SIM_EN to replace CLK_HZ/TICK_HZ with SIM_DIV for fast simulation.
module tick_timer #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1,
    parameter int CNT_W   = 8,
    parameter int SIM_DIV = 50
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick,
    output logic             expired,
    output logic             busy,
    output logic [CNT_W-1:0] remaining
);
`ifdef TIMER_SIM_EN
    localparam bit USE_SIM = 1'b1;
`else
    localparam bit USE_SIM = 1'b0;
`endif
    localparam int DIV   = USE_SIM ? SIM_DIV : CLK_HZ / TICK_HZ;
    localparam int PRE_W = $clog2(DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             exp_q, exp_d;

    assign busy      = state_q != IDLE;
    assign remaining = rem_q;
    assign tick      = tick_q;
    assign expired   = exp_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            pre_q    <= '0;
            rem_q    <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            tick_q   <= 1'b0;
            exp_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            rem_q    <= rem_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            tick_q   <= tick_d;
            exp_q    <= exp_d;
        end
    end

    // Leaving PAUSED with enable high counts on that same edge, so the partial period is kept exactly.
    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        rem_d    = rem_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        tick_d   = 1'b0;
        exp_d    = 1'b0;
        if (stop) begin
            if (busy) begin
                state_d = IDLE;
                pre_d   = '0;
                rem_d   = '0;
            end
        end else if (start) begin
            if (load_val != '0) begin
                state_d  = RUN;
                pre_d    = '0;
                rem_d    = load_val;
                reload_d = load_val;
                mode_d   = mode;
            end else if (busy) begin
                state_d = IDLE;
                pre_d   = '0;
                rem_d   = '0;
            end
        end else if (busy) begin
            if (!enable) begin
                state_d = PAUSED;
            end else if (pre_q != PRE_LAST) begin
                state_d = RUN;
                pre_d   = pre_q + 1'b1;
            end else begin
                state_d = RUN;
                pre_d   = '0;
                tick_d  = 1'b1;
                if (rem_q > CNT_W'(1)) begin
                    rem_d = rem_q - 1'b1;
                end else begin
                    exp_d   = 1'b1;
                    rem_d   = mode_q ? reload_q : '0;
                    state_d = mode_q ? RUN : IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_tick_timer.sv
// tb_tick_timer: directed scenarios with closed-form expectations plus a random run against an elapsed-time model.
module tb_tick_timer;
    localparam int DIV = 5;
    localparam int W   = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         tick, expired, busy;
    logic [W-1:0] remaining;

    int n_tests = 0;
    int n_fail  = 0;

    bit m_act, m_md, m_tick, m_exp;
    int m_ld, m_el, m_rem;

    always #5 clk = ~clk;

    tick_timer #(.CLK_HZ(DIV), .TICK_HZ(1), .CNT_W(W), .SIM_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .stop(stop),
        .mode(mode), .load_val(load_val), .tick(tick), .expired(expired),
        .busy(busy), .remaining(remaining)
    );

    wire [W+2:0] obs = {tick, expired, busy, remaining};

    function automatic logic [W+2:0] vec(input bit t, input bit e, input bit b, input int r);
        return {t, e, b, r[W-1:0]};
    endfunction

    // Model: counts enabled cycles since the last accepted start; ticks are every DIV-th such cycle.
    task automatic model_step();
        m_tick = 0;
        m_exp  = 0;
        if (!reset) begin
            m_act = 0; m_rem = 0; m_el = 0;
        end else if (stop) begin
            if (m_act) begin m_act = 0; m_rem = 0; end
        end else if (start) begin
            if (load_val != 0) begin
                m_act = 1; m_ld = int'(load_val); m_md = mode; m_el = 0; m_rem = m_ld;
            end else if (m_act) begin
                m_act = 0; m_rem = 0;
            end
        end else if (m_act && enable) begin
            m_el++;
            if (m_el % DIV == 0) begin
                int n;
                n = m_el / DIV;
                m_tick = 1;
                m_exp = (n % m_ld == 0);
                if (m_md) m_rem = m_ld - n % m_ld;
                else begin
                    m_rem = m_ld - n;
                    if (m_rem == 0) m_act = 0;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic go(input logic st, input logic sp, input logic en, input logic md, input logic [W-1:0] lv);
        start = st; stop = sp; enable = en; mode = md; load_val = lv;
    endtask

    task automatic test_reset();
        go(1, 0, 1, 0, 5);
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_tests++;
            if (obs !== '0) begin n_fail++; $display("FAIL reset_hold cyc %0d: got %h expected 0", i, obs); end
        end
        reset = 1'b1;
        go(0, 0, 1, 0, 5);
        for (int i = 0; i < 6; i++) begin
            cyc();
            n_tests++;
            if (obs !== '0) begin n_fail++; $display("FAIL reset_idle cyc %0d: got %h expected 0", i, obs); end
        end
    endtask

    task automatic test_one_shot();
        logic [W+2:0] e;
        go(1, 0, 1, 0, 3);
        cyc();
        go(0, 0, 1, 0, 3);
        n_tests++;
        if (obs !== vec(0, 0, 1, 3)) begin n_fail++; $display("FAIL one_shot_load: got %h expected %h", obs, vec(0, 0, 1, 3)); end
        for (int k = 1; k <= 17; k++) begin
            cyc();
            e = vec(k % 5 == 0 && k <= 15, k == 15, k < 15, k < 15 ? 3 - k / 5 : 0);
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL one_shot E+%0d: got %h expected %h", k, obs, e); end
        end
    endtask

    task automatic test_periodic();
        logic [W+2:0] e;
        go(1, 0, 1, 1, 2);
        cyc();
        go(0, 0, 1, 0, 0);
        for (int k = 1; k <= 32; k++) begin
            cyc();
            e = vec(k % 5 == 0, k % 10 == 0, 1, 2 - (k / 5) % 2);
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL periodic E+%0d: got %h expected %h", k, obs, e); end
        end
        go(0, 1, 1, 0, 0);
        cyc();
        go(0, 0, 1, 0, 0);
        n_tests++;
        if (obs !== '0) begin n_fail++; $display("FAIL periodic_stop: got %h expected 0", obs); end
    endtask

    task automatic test_pause();
        logic [W+2:0] e;
        go(1, 0, 1, 0, 1);
        cyc();
        go(0, 0, 1, 0, 0);
        for (int k = 1; k <= 15; k++) begin
            enable = !(k >= 2 && k <= 8);
            cyc();
            e = vec(k == 12, k == 12, k < 12, k < 12 ? 1 : 0);
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL pause E+%0d: got %h expected %h", k, obs, e); end
        end
    endtask

    task automatic test_stop();
        logic [W+2:0] e;
        go(1, 0, 1, 0, 4);
        cyc();
        go(0, 0, 1, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            stop = (k == 7);
            cyc();
            e = k < 7 ? vec(k == 5, 0, 1, k < 5 ? 4 : 3) : '0;
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL stop E+%0d: got %h expected %h", k, obs, e); end
        end
        stop = 1'b0;
    endtask

    task automatic test_restart();
        logic [W+2:0] e;
        int j;
        go(1, 0, 1, 0, 4);
        cyc();
        for (int k = 1; k <= 20; k++) begin
            go(k == 7, 0, 1, 0, 2);
            cyc();
            j = k - 7;
            e = k < 7 ? vec(k == 5, 0, 1, k < 5 ? 4 : 3)
                      : vec(j == 5 || j == 10, j == 10, j < 10, j < 5 ? 2 : (j < 10 ? 1 : 0));
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL restart E+%0d: got %h expected %h", k, obs, e); end
        end
    endtask

    task automatic test_start_stop();
        logic [W+2:0] e;
        go(1, 0, 1, 0, 3);
        cyc();
        for (int k = 1; k <= 8; k++) begin
            go(k == 3, k == 3, 1, 1, 5);
            cyc();
            e = k < 3 ? vec(0, 0, 1, 3) : '0;
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL start_stop E+%0d: got %h expected %h", k, obs, e); end
        end
    endtask

    task automatic test_zero_load();
        logic [W+2:0] e;
        for (int k = 0; k <= 20; k++) begin
            go(k == 0, 0, 1, 1, 0);
            cyc();
            n_tests++;
            if (obs !== '0) begin n_fail++; $display("FAIL zero_idle cyc %0d: got %h expected 0", k, obs); end
        end
        go(1, 0, 1, 0, 3);
        cyc();
        for (int k = 1; k <= 6; k++) begin
            go(k == 2, 0, 1, 0, 0);
            cyc();
            e = k < 2 ? vec(0, 0, 1, 3) : '0;
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL zero_restart E+%0d: got %h expected %h", k, obs, e); end
        end
    endtask

    task automatic test_max_load();
        logic [W+2:0] e;
        go(1, 0, 1, 0, 255);
        cyc();
        go(0, 0, 1, 0, 0);
        for (int k = 1; k <= 1280; k++) begin
            cyc();
            e = vec(k % 5 == 0 && k <= 1275, k == 1275, k < 1275, k < 1275 ? 255 - k / 5 : 0);
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL max_load E+%0d: got %h expected %h", k, obs, e); end
        end
    endtask

    task automatic test_random();
        logic [W+2:0] e;
        for (int k = 0; k < 4000; k++) begin
            reset    = ($urandom_range(299) != 0);
            start    = ($urandom_range(39) == 0);
            stop     = ($urandom_range(79) == 0);
            enable   = ($urandom_range(7) != 0);
            mode     = 1'($urandom_range(1));
            load_val = ($urandom_range(9) == 0) ? ($urandom_range(1) == 0 ? W'(0) : W'(255))
                                                : W'($urandom_range(6, 1));
            cyc();
            e = vec(m_tick, m_exp, m_act, m_rem);
            n_tests++;
            if (obs !== e) begin n_fail++; $display("FAIL random cyc %0d: got %h expected %h", k, obs, e); end
        end
        reset = 1'b1;
        go(0, 0, 1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_periodic();
        test_pause();
        test_stop();
        test_restart();
        test_start_stop();
        test_zero_load();
        test_max_load();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
